// File: rtl/divider.sv
// rtl/divider.sv - sequential restoring divider with load/start/done handshake
//
// Divides an N_W-bit dividend by a D_W-bit divisor, one quotient bit per
// clock, using the same load/start/done handshake as the shift-add multiplier.
//
// Parameters:
//   N_W      dividend / quotient width
//   D_W      divisor / remainder width (D_W <= N_W)
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    asynchronous active-high reset
//   i_load   capture i_N / i_D (honoured in IDLE and DONE, ignored in CALC)
//   i_start  begin a division on the captured operands (ignored in CALC)
//   i_N      dividend
//   i_D      divisor
//   o_busy   high while computing
//   o_done   high while a result is presented (level)
//   o_Q      quotient (all ones on divide by zero)
//   o_R      remainder (0 on divide by zero)
//   o_div0   last completed operation had a zero divisor

module divider #(
    parameter int N_W = 8,
    parameter int D_W = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_load,
    input  logic           i_start,
    input  logic [N_W-1:0] i_N,
    input  logic [D_W-1:0] i_D,
    output logic           o_busy,
    output logic           o_done,
    output logic [N_W-1:0] o_Q,
    output logic [D_W-1:0] o_R,
    output logic           o_div0
);

    localparam int CNT_W = $clog2(N_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Captured operands
    logic [N_W-1:0] n_q, n_d;
    logic [D_W-1:0] dv_q, dv_d;

    // Working registers: partial remainder, dividend/quotient shifter, counter
    logic [D_W:0]     p_q, p_d;
    logic [N_W-1:0]   s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Result registers
    logic [N_W-1:0] q_q, q_d;
    logic [D_W-1:0] r_q, r_d;
    logic           div0_q, div0_d;

    // One restoring step. P never exceeds D-1 < 2^D_W between steps, so only
    // its low D_W bits feed the next trial value T.
    logic [D_W:0]   trial;
    logic           q_bit;
    logic [D_W:0]   p_step;
    logic [N_W-1:0] s_step;

    always_comb begin
        trial  = {p_q[D_W-1:0], s_q[N_W-1]};
        q_bit  = (trial >= {1'b0, dv_q});
        p_step = q_bit ? (trial - {1'b0, dv_q}) : trial;
        s_step = (s_q << 1) | N_W'(q_bit);
    end

    logic divisor_zero;
    assign divisor_zero = (dv_q == '0);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        dv_d    = dv_q;
        p_d     = p_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        div0_d  = div0_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // Load wins over a same-cycle start.
                if (i_load) begin
                    n_d     = i_N;
                    dv_d    = i_D;
                    state_d = ST_IDLE;
                end else if (i_start) begin
                    if (divisor_zero) begin
                        // Resolved immediately: no iterations needed.
                        q_d     = '1;
                        r_d     = '0;
                        div0_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        p_d     = '0;
                        s_d     = n_q;
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                p_d   = p_step;
                s_d   = s_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    // Results are taken from the final step directly so they
                    // become visible on the same edge that enters DONE.
                    q_d     = s_step;
                    r_d     = p_step[D_W-1:0];
                    div0_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            dv_q    <= '0;
            p_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            dv_q    <= dv_d;
            p_q     <= p_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
        end
    end

    assign o_busy = (state_q == ST_CALC);
    assign o_done = (state_q == ST_DONE);
    assign o_Q    = q_q;
    assign o_R    = r_q;
    assign o_div0 = div0_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - self-checking bench for divider against an arithmetic model
module tb_divider;

    localparam int N_W = 8;
    localparam int D_W = 4;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic           i_load;
    logic           i_start;
    logic [N_W-1:0] i_N;
    logic [D_W-1:0] i_D;
    logic           o_busy;
    logic           o_done;
    logic [N_W-1:0] o_Q;
    logic [D_W-1:0] o_R;
    logic           o_div0;

    int tests = 0;
    int fails = 0;

    divider #(.N_W(N_W), .D_W(D_W)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (i_load),
        .i_start(i_start),
        .i_N    (i_N),
        .i_D    (i_D),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_Q    (o_Q),
        .o_R    (o_R),
        .o_div0 (o_div0)
    );

    always #5 i_clk = ~i_clk;

    // Reference: plain integer division on the operand values.
    function automatic void model(input int n, input int d,
                                  output logic [N_W-1:0] q, output logic [D_W-1:0] r,
                                  output logic z);
        if (d == 0) begin
            q = '1; r = '0; z = 1'b1;
        end else begin
            q = N_W'(n / d); r = D_W'(n % d); z = 1'b0;
        end
    endfunction

    task automatic do_load(input int n, input int d);
        @(negedge i_clk);
        i_load = 1'b1; i_N = N_W'(n); i_D = D_W'(d);
        @(negedge i_clk);
        i_load = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Called on the negedge right after the start edge; counts edges to DONE.
    task automatic wait_done(output int cycles, output int busy_cnt,
                             output bit overlap, output bit timeout);
        cycles = 0; busy_cnt = 0; overlap = 0; timeout = 0;
        while (!o_done) begin
            if (o_busy) busy_cnt++;
            if (cycles >= 40) begin
                timeout = 1;
                break;
            end
            @(negedge i_clk);
            cycles++;
        end
        if (o_busy && o_done) overlap = 1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_load = 1'b0; i_start = 1'b0; i_N = '0; i_D = '0;
        repeat (2) @(negedge i_clk);
        tests++;
        if ({o_busy, o_done, o_Q, o_R, o_div0} !== '0) begin
            $display("FAIL reset_outputs got busy=%b done=%b Q=%0d R=%0d div0=%b expected all 0",
                     o_busy, o_done, o_Q, o_R, o_div0);
            fails++;
        end
        i_rst = 1'b0;
        // Starting with reset operands (divisor 0) must report divide by zero.
        pulse_start();
        tests++;
        if (!(o_done && o_div0 && o_Q == 8'hFF && o_R == 0)) begin
            $display("FAIL reset_operands_zero got done=%b div0=%b Q=%0d R=%0d expected 1 1 255 0",
                     o_done, o_div0, o_Q, o_R);
            fails++;
        end
    endtask

    // Runs one load/start/wait and checks result, latency, busy count.
    task automatic run_and_check(input string name, input int n, input int d);
        logic [N_W-1:0] eq; logic [D_W-1:0] er; logic ez;
        int cyc, bc; bit ov, to;
        int exp_cyc;
        model(n, d, eq, er, ez);
        exp_cyc = (d == 0) ? 0 : N_W;
        do_load(n, d);
        pulse_start();
        wait_done(cyc, bc, ov, to);
        tests++;
        if (to || ov || cyc != exp_cyc || bc != exp_cyc ||
            o_Q !== eq || o_R !== er || o_div0 !== ez) begin
            $display("FAIL %s n=%0d d=%0d got Q=%0d R=%0d div0=%b lat=%0d busy=%0d ov=%b to=%b expected Q=%0d R=%0d div0=%b lat=%0d",
                     name, n, d, o_Q, o_R, o_div0, cyc, bc, ov, to, eq, er, ez, exp_cyc);
            fails++;
        end
    endtask

    task automatic test_directed();
        int tn[5] = '{255, 200, 5, 100, 100};
        int td[5] = '{15, 7, 9, 0, 3};
        for (int i = 0; i < 5; i++) run_and_check("directed", tn[i], td[i]);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_and_check("random", int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
    endtask

    task automatic test_calc_ignores();
        int cyc, bc; bit ov, to;
        do_load(200, 7);
        pulse_start();
        @(negedge i_clk);
        i_load = 1'b1; i_N = 8'd9; i_D = 4'd3;
        @(negedge i_clk);
        i_load = 1'b0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(cyc, bc, ov, to);
        tests++;
        if (to || cyc != N_W - 3 || o_Q !== 8'd28 || o_R !== 4'd4 || o_div0 !== 1'b0) begin
            $display("FAIL calc_ignores got Q=%0d R=%0d div0=%b rem_lat=%0d to=%b expected 28 4 0 %0d",
                     o_Q, o_R, o_div0, cyc, to, N_W - 3);
            fails++;
        end
        pulse_start();
        tests++;
        if (o_done !== 1'b0 || o_busy !== 1'b1 || o_Q !== 8'd28) begin
            $display("FAIL restart_edge got done=%b busy=%b Q=%0d expected 0 1 28", o_done, o_busy, o_Q);
            fails++;
        end
        wait_done(cyc, bc, ov, to);
        tests++;
        if (to || ov || cyc != N_W || o_Q !== 8'd28 || o_R !== 4'd4) begin
            $display("FAIL restart_result got Q=%0d R=%0d lat=%0d to=%b expected 28 4 %0d",
                     o_Q, o_R, cyc, to, N_W);
            fails++;
        end
    endtask

    task automatic test_load_hold();
        run_and_check("hold_setup", 200, 7);
        do_load(13, 5);
        tests++;
        if (o_done !== 1'b0 || o_Q !== 8'd28 || o_R !== 4'd4 || o_div0 !== 1'b0) begin
            $display("FAIL load_hold got done=%b Q=%0d R=%0d div0=%b expected 0 28 4 0",
                     o_done, o_Q, o_R, o_div0);
            fails++;
        end
        // Same-cycle load and start: load wins, no computation begins.
        @(negedge i_clk);
        i_load = 1'b1; i_start = 1'b1; i_N = 8'd50; i_D = 4'd6;
        @(negedge i_clk);
        i_load = 1'b0; i_start = 1'b0;
        tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            $display("FAIL load_wins got busy=%b done=%b expected 0 0", o_busy, o_done);
            fails++;
        end
        run_and_check("after_load_wins", 50, 6);
    endtask

    task automatic test_reset_mid_calc();
        do_load(255, 15);
        pulse_start();
        repeat (3) @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        tests++;
        if ({o_busy, o_done, o_Q, o_R, o_div0} !== '0) begin
            $display("FAIL reset_mid_calc got busy=%b done=%b Q=%0d R=%0d div0=%b expected all 0",
                     o_busy, o_done, o_Q, o_R, o_div0);
            fails++;
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_Q !== 8'd0) begin
            $display("FAIL reset_stays_idle got busy=%b done=%b Q=%0d expected 0 0 0", o_busy, o_done, o_Q);
            fails++;
        end
        run_and_check("post_reset", 255, 15);
    endtask

    task automatic test_sweep();
        int cyc, bc; bit ov, to;
        for (int n = 0; n < 256; n++) begin
            for (int d = 1; d < 16; d++) begin
                do_load(n, d);
                pulse_start();
                wait_done(cyc, bc, ov, to);
                tests++;
                if (to || ov || (int'(o_Q) * d + int'(o_R)) != n || int'(o_R) >= d ||
                    int'(o_Q) != n / d || o_div0 !== 1'b0) begin
                    $display("FAIL sweep n=%0d d=%0d got Q=%0d R=%0d div0=%b to=%b expected Q=%0d R=%0d",
                             n, d, o_Q, o_R, o_div0, to, n / d, n % d);
                    fails++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_calc_ignores();
        test_load_hold();
        test_reset_mid_calc();
        test_random();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
